// File: rtl/sdram_arbiter.sv
// Round-robin arbiter funnelling NP requester ports onto one SDRAM controller port.
// Read responses are routed back in order using a FIFO of requester tags.
module sdram_arbiter #(
    parameter int unsigned NP = 2,
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 16,
    parameter int unsigned TD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NP-1:0]            s_req_valid,
    input  logic [NP-1:0]            s_req_write,
    input  logic [NP*AW-1:0]         s_req_addr,
    input  logic [NP*DW-1:0]         s_req_wdata,
    input  logic [NP*(DW/8)-1:0]     s_req_byteenable,
    output logic [NP-1:0]            s_req_ready,
    output logic [NP-1:0]            s_rsp_early_valid,
    output logic [NP-1:0]            s_rsp_valid,
    output logic [DW-1:0]            s_rsp_rdata,
    output logic                     m_req_valid,
    output logic                     m_req_write,
    output logic [AW-1:0]            m_req_addr,
    output logic [DW-1:0]            m_req_wdata,
    output logic [DW/8-1:0]          m_req_byteenable,
    input  logic                     m_req_ready,
    input  logic                     m_rsp_early_valid,
    input  logic                     m_rsp_valid,
    input  logic [DW-1:0]            m_rsp_rdata,
    output logic [$clog2(TD):0]      rd_outstanding,
    output logic                     err_orphan_rsp
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int unsigned FW = $clog2(TD);
    localparam int unsigned CW = FW + 1;

    logic [PW-1:0] r_ptr;
    logic          r_lock;
    logic [PW-1:0] r_lock_port;
    logic [PW-1:0] r_tag [TD];
    logic [FW-1:0] r_head;
    logic [FW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_orphan;

    logic [NP-1:0] w_elig;
    logic          w_rr_found;
    logic [PW-1:0] w_rr_port;
    logic [PW-1:0] w_grant;
    logic          w_mvalid;
    logic          w_hs;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [PW-1:0] w_head_port;

    // Reads are held off from the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        for (int i = 0; i < int'(NP); i++) begin
            w_elig[i] = s_req_valid[i] & (s_req_write[i] | (r_count < CW'(TD)));
        end
    end

    // Round-robin search from r_ptr; iterating downward leaves the nearest eligible port as winner.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_port  = '0;
        for (int k = int'(NP) - 1; k >= 0; k--) begin
            if (w_elig[(32'(r_ptr) + 32'(k)) % NP]) begin
                w_rr_found = 1'b1;
                w_rr_port  = PW'((32'(r_ptr) + 32'(k)) % NP);
            end
        end
    end

    assign w_grant     = r_lock ? r_lock_port : w_rr_port;
    assign w_mvalid    = ~rst & (r_lock ? w_elig[w_grant] : w_rr_found);
    assign w_hs        = w_mvalid & m_req_ready;
    assign w_push      = w_hs & ~s_req_write[w_grant];
    assign w_nonempty  = (r_count != '0);
    assign w_pop       = ~rst & m_rsp_valid & w_nonempty;
    assign w_head_port = r_tag[r_head];

    assign m_req_valid      = w_mvalid;
    assign m_req_write      = s_req_write[w_grant];
    assign m_req_addr       = s_req_addr[32'(w_grant) * AW +: AW];
    assign m_req_wdata      = s_req_wdata[32'(w_grant) * DW +: DW];
    assign m_req_byteenable = s_req_byteenable[32'(w_grant) * BW +: BW];

    assign s_req_ready       = w_hs ? (NP'(1) << w_grant) : '0;
    assign s_rsp_valid       = w_pop ? (NP'(1) << w_head_port) : '0;
    assign s_rsp_early_valid = (~rst & m_rsp_early_valid & w_nonempty) ? (NP'(1) << w_head_port) : '0;
    assign s_rsp_rdata       = m_rsp_rdata;

    assign rd_outstanding = r_count;
    assign err_orphan_rsp = r_orphan;

    // Grant pointer, lock and tag FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_lock      <= 1'b0;
            r_lock_port <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_orphan    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_ptr  <= (w_grant == PW'(NP - 1)) ? '0 : w_grant + PW'(1);
                r_lock <= 1'b0;
            end else if (w_mvalid) begin
                r_lock      <= 1'b1;
                r_lock_port <= w_grant;
            end
            if (w_push) begin
                r_tail <= r_tail + FW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + FW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (m_rsp_valid & ~w_nonempty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_tail] <= w_grant;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a directed vector table followed by randomized traffic
// checked against a queue-based reference model.
module tb_sdram_arbiter;

    localparam int unsigned NP = 2;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;
    localparam int unsigned TD = 4;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = $clog2(TD) + 1;
    localparam logic [AW-1:0] A0 = 24'h000100;
    localparam logic [AW-1:0] A1 = 24'h000123;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     s_req_valid;
    logic [NP-1:0]     s_req_write;
    logic [NP*AW-1:0]  s_req_addr;
    logic [NP*DW-1:0]  s_req_wdata;
    logic [NP*BW-1:0]  s_req_byteenable;
    logic [NP-1:0]     s_req_ready;
    logic [NP-1:0]     s_rsp_early_valid;
    logic [NP-1:0]     s_rsp_valid;
    logic [DW-1:0]     s_rsp_rdata;
    logic              m_req_valid;
    logic              m_req_write;
    logic [AW-1:0]     m_req_addr;
    logic [DW-1:0]     m_req_wdata;
    logic [BW-1:0]     m_req_byteenable;
    logic              m_req_ready;
    logic              m_rsp_early_valid;
    logic              m_rsp_valid;
    logic [DW-1:0]     m_rsp_rdata;
    logic [CW-1:0]     rd_outstanding;
    logic              err_orphan_rsp;

    sdram_arbiter #(.NP(NP), .AW(AW), .DW(DW), .TD(TD)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_req_valid       (s_req_valid),
        .s_req_write       (s_req_write),
        .s_req_addr        (s_req_addr),
        .s_req_wdata       (s_req_wdata),
        .s_req_byteenable  (s_req_byteenable),
        .s_req_ready       (s_req_ready),
        .s_rsp_early_valid (s_rsp_early_valid),
        .s_rsp_valid       (s_rsp_valid),
        .s_rsp_rdata       (s_rsp_rdata),
        .m_req_valid       (m_req_valid),
        .m_req_write       (m_req_write),
        .m_req_addr        (m_req_addr),
        .m_req_wdata       (m_req_wdata),
        .m_req_byteenable  (m_req_byteenable),
        .m_req_ready       (m_req_ready),
        .m_rsp_early_valid (m_rsp_early_valid),
        .m_rsp_valid       (m_rsp_valid),
        .m_rsp_rdata       (m_rsp_rdata),
        .rd_outstanding    (rd_outstanding),
        .err_orphan_rsp    (err_orphan_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        bit            rst;
        logic [1:0]    v;
        logic [1:0]    w;
        bit            rdy;
        bit            rv;
        logic [15:0]   rd;
        bit            e_mv;
        logic [23:0]   e_addr;
        logic [1:0]    e_rdy;
        logic [1:0]    e_srv;
        int            e_out;
        bit            e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [1:0] v, logic [1:0] w, bit rdy, bit rv, logic [15:0] rd,
                                bit mv, logic [23:0] ad, logic [1:0] sr, logic [1:0] srv, int out, bit err);
        vec_t t;
        t.rst = r; t.v = v; t.w = w; t.rdy = rdy; t.rv = rv; t.rd = rd;
        t.e_mv = mv; t.e_addr = ad; t.e_rdy = sr; t.e_srv = srv; t.e_out = out; t.e_err = err;
        return t;
    endfunction

    // Reference model state
    int          m_ptr;
    bit          m_lock;
    int          m_lport;
    int          m_q[$];
    bit          m_err;
    logic [NP-1:0] cv, cw;
    logic [AW-1:0] ca [NP];
    logic [DW-1:0] cd [NP];
    logic [BW-1:0] cb [NP];

    initial begin
        rst = 1'b1;
        s_req_valid = '0; s_req_write = '0; s_req_addr = '0; s_req_wdata = '0; s_req_byteenable = '0;
        m_req_ready = 1'b0; m_rsp_early_valid = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0;

        //          rst v      w      rdy rv  rd        mv  addr rdy   srv  out err
        tbl.push_back(mk(1, 2'b11, 2'b11, 1, 0, 16'h0000, 0, A0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, 0, 16'h0000, 1, A1, 2'b10, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b11, 1, 0, 16'h0000, 1, A1, 2'b10, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 16'h0000, 1, A1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 16'h0000, 1, A1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 16'h0000, 1, A1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, 0, 16'h0000, 1, A1, 2'b10, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'hAAAA, 0, A0, 2'b00, 2'b10, 2, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h5555, 0, A0, 2'b00, 2'b01, 1, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 1, 0, 16'h0000, 1, A1, 2'b10, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'hAAAA, 0, A0, 2'b00, 2'b01, 2, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h5555, 0, A0, 2'b00, 2'b10, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, 0, 16'h0000, 1, A1, 2'b10, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 2, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 1, 0, 16'h0000, 1, A1, 2'b10, 2'b00, 3, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 0, A0, 2'b00, 2'b00, 4, 0));
        tbl.push_back(mk(0, 2'b11, 2'b10, 1, 0, 16'h0000, 1, A1, 2'b10, 2'b00, 4, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 1, 16'h1111, 0, A0, 2'b00, 2'b01, 4, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 3, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h2222, 0, A0, 2'b00, 2'b10, 4, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h3333, 0, A0, 2'b00, 2'b01, 3, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 1, 16'h4444, 1, A0, 2'b01, 2'b10, 2, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h5555, 0, A0, 2'b00, 2'b01, 2, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h6666, 0, A0, 2'b00, 2'b01, 1, 0));
        tbl.push_back(mk(1, 2'b11, 2'b00, 1, 0, 16'h0000, 0, A0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h7777, 0, A0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, A0, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0000, 0, A0, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, A0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, A0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b00, 1, 1, 16'h8888, 0, A0, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 16'h9999, 0, A0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, A0, 2'b00, 2'b00, 0, 1));

        repeat (2) @(negedge clk);

        // Directed table: one row per cycle, outputs sampled mid-cycle
        for (int i = 0; i < tbl.size(); i++) begin
            rst              = tbl[i].rst;
            s_req_valid      = tbl[i].v;
            s_req_write      = tbl[i].w;
            s_req_addr       = {A1, A0};
            s_req_wdata      = {DW'($urandom), DW'($urandom)};
            s_req_byteenable = '1;
            m_req_ready      = tbl[i].rdy;
            m_rsp_valid      = tbl[i].rv;
            m_rsp_rdata      = tbl[i].rd;
            m_rsp_early_valid = 1'b0;
            #1;
            chk($sformatf("row%0d m_req_valid", i), m_req_valid, tbl[i].e_mv);
            if (tbl[i].e_mv) chk($sformatf("row%0d m_req_addr", i), m_req_addr, tbl[i].e_addr);
            chk($sformatf("row%0d s_req_ready", i), s_req_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d s_rsp_valid", i), s_rsp_valid, tbl[i].e_srv);
            if (tbl[i].rv) chk($sformatf("row%0d s_rsp_rdata", i), s_rsp_rdata, tbl[i].rd);
            chk($sformatf("row%0d rd_outstanding", i), rd_outstanding, longint'(tbl[i].e_out));
            chk($sformatf("row%0d err_orphan_rsp", i), err_orphan_rsp, tbl[i].e_err);
            @(negedge clk);
        end

        // Bring DUT and model to a common reset state before random traffic
        rst = 1'b1; s_req_valid = '0; m_rsp_valid = 1'b0; m_rsp_early_valid = 1'b0;
        @(negedge clk);
        m_ptr = 0; m_lock = 0; m_lport = 0; m_q.delete(); m_err = 0;
        cv = '0; cw = '0;
        for (int i = 0; i < int'(NP); i++) begin ca[i] = '0; cd[i] = '0; cb[i] = '0; end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          r_in, rdy_in, rv_in, ev_in;
            bit          elig [NP];
            bit          e_mv;
            int          g;
            int          sz;
            logic [NP-1:0] e_rdy, e_srv, e_ev;

            r_in = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < int'(NP); i++) begin
                if (!(m_lock && i == m_lport)) begin
                    cv[i] = ($urandom_range(0, 2) != 0);
                    cw[i] = 1'($urandom_range(0, 1));
                    ca[i] = AW'($urandom);
                    cd[i] = DW'($urandom);
                    cb[i] = BW'($urandom);
                end
                s_req_addr[i*AW +: AW]       = ca[i];
                s_req_wdata[i*DW +: DW]      = cd[i];
                s_req_byteenable[i*BW +: BW] = cb[i];
            end
            rdy_in = ($urandom_range(0, 2) != 0);
            rv_in  = ($urandom_range(0, 2) == 0);
            ev_in  = ($urandom_range(0, 3) == 0);
            rst = r_in; s_req_valid = cv; s_req_write = cw;
            m_req_ready = rdy_in; m_rsp_valid = rv_in; m_rsp_early_valid = ev_in;
            m_rsp_rdata = DW'($urandom);
            #1;

            sz = m_q.size();
            e_mv = 0; g = 0; e_rdy = '0; e_srv = '0; e_ev = '0;
            for (int i = 0; i < int'(NP); i++) elig[i] = cv[i] && (cw[i] || sz < int'(TD));
            if (!r_in) begin
                if (m_lock) begin
                    g = m_lport; e_mv = elig[g];
                end else begin
                    for (int k = 0; k < int'(NP); k++) begin
                        int p;
                        p = (m_ptr + k) % int'(NP);
                        if (!e_mv && elig[p]) begin e_mv = 1; g = p; end
                    end
                end
                if (e_mv && rdy_in) e_rdy[g] = 1'b1;
                if (rv_in && sz > 0) e_srv[m_q[0]] = 1'b1;
                if (ev_in && sz > 0) e_ev[m_q[0]] = 1'b1;
            end

            chk("rnd m_req_valid", m_req_valid, e_mv);
            if (e_mv) begin
                chk("rnd m_req_addr", m_req_addr, ca[g]);
                chk("rnd m_req_write", m_req_write, cw[g]);
                chk("rnd m_req_wdata", m_req_wdata, cd[g]);
                chk("rnd m_req_byteenable", m_req_byteenable, cb[g]);
            end
            chk("rnd s_req_ready", s_req_ready, e_rdy);
            chk("rnd s_rsp_valid", s_rsp_valid, e_srv);
            chk("rnd s_rsp_early_valid", s_rsp_early_valid, e_ev);
            if (rv_in) chk("rnd s_rsp_rdata", s_rsp_rdata, m_rsp_rdata);
            chk("rnd rd_outstanding", rd_outstanding, longint'(sz));
            chk("rnd err_orphan_rsp", err_orphan_rsp, m_err);

            // Model next state
            if (r_in) begin
                m_ptr = 0; m_lock = 0; m_q.delete(); m_err = 0;
            end else begin
                if (rv_in) begin
                    if (sz > 0) void'(m_q.pop_front());
                    else m_err = 1;
                end
                if (e_mv && rdy_in) begin
                    m_ptr = (g + 1) % int'(NP);
                    m_lock = 0;
                    if (!cw[g]) m_q.push_back(g);
                end else if (e_mv) begin
                    m_lock = 1; m_lport = g;
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NP, default 2: number of requester ports (2..8).
REQ-002 Parameter AW, default 24: bus address width.
REQ-003 Parameter DW, default 16: bus data width, multiple of 8.
REQ-004 Parameter TD, default 4: outstanding-read tag FIFO depth (power of 2, >=2).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 s_req_valid  in  NP  per-port request valid.
REQ-008 s_req_write  in  NP  per-port write (1) / read (0).
REQ-009 s_req_addr  in  NP*AW  per-port address; port i at bits [i*AW +: AW].
REQ-010 s_req_wdata  in  NP*DW  per-port write data, packed the same way.
REQ-011 s_req_byteenable  in  NP*DW/8  per-port byte enables, packed the same way.
REQ-012 s_req_ready  out  NP  per-port request accepted.
REQ-013 s_rsp_early_valid  out  NP  controller early-valid, routed to the owning port.
REQ-014 s_rsp_valid  out  NP  read data valid, routed to the owning port.
REQ-015 s_rsp_rdata  out  DW  read data, broadcast to all ports.
REQ-016 m_req_valid, m_req_write  out  1 each; m_req_addr out AW; m_req_wdata out DW; m_req_byteenable out DW/8: request to sdram_controller.
REQ-017 m_req_ready  in  1  controller accepts the request.
REQ-018 m_rsp_early_valid, m_rsp_valid  in  1 each; m_rsp_rdata in DW: controller responses.
REQ-019 rd_outstanding  out  $clog2(TD)+1  count of reads accepted but not yet answered.
REQ-020 err_orphan_rsp  out  1  sticky: m_rsp_valid arrived while no read was outstanding.

Function
REQ-021 Arbitration SHALL be round-robin: search starts at port ptr, wraps modulo NP; the first port with s_req_valid wins.
REQ-022 Port i is eligible when s_req_valid[i]=1 and (s_req_write[i]=1 or rd_outstanding<TD); reads are ineligible while the FIFO is full, and a same-cycle pop SHALL NOT bypass this check.
REQ-023 Once m_req_valid is 1 without m_req_ready, the grant SHALL lock onto that port; m_req_* stays stable until the handshake (valid&ready).
REQ-024 m_req_* SHALL be a combinational mux of the granted port; m_req_valid=0 when no port is eligible.
REQ-025 s_req_ready[i] = m_req_ready & m_req_valid & (grant==i); all other ready bits 0.
REQ-026 On handshake ptr SHALL load (grant+1) mod NP and the lock SHALL clear; grant is free again the next cycle (zero-bubble back-to-back).
REQ-027 On a read handshake the granted port index SHALL be pushed into the tag FIFO.
REQ-028 m_rsp_valid with the FIFO non-empty SHALL pop the head and assert s_rsp_valid[head] in the same cycle.
REQ-029 m_rsp_early_valid SHALL be routed to s_rsp_early_valid[head] when non-empty, else dropped.
REQ-030 Simultaneous push and pop: rd_outstanding unchanged; head advances; FIFO pointers wrap modulo TD.
REQ-031 m_rsp_valid with the FIFO empty: no s_rsp_valid asserted; err_orphan_rsp set to 1 and held until reset.
REQ-032 Writes SHALL NOT enter the FIFO and produce no s_rsp_valid.

Reset
REQ-033 While rst=1: ptr=0, lock=0, FIFO empty, rd_outstanding=0, err_orphan_rsp=0; all s_req_ready, s_rsp_valid and s_rsp_early_valid SHALL be 0 and m_req_valid=0, overriding inputs, even mid-transfer.
REQ-034 Reads in flight at reset are forgotten; their late responses SHALL be flagged as orphans.

Verification
REQ-035 Ports 0 and 1 both request writes continuously with m_req_ready=1 -> grants alternate 0,1,0,1 every cycle starting with port 0.
REQ-036 Port 1 reads addr 0x000123 with m_req_ready=0 for 3 cycles while port 0 raises a request -> m_req_addr is held at 0x000123 and port 1 stays granted until ready; port 0 is granted next.
REQ-037 Port 0 reads, then port 1 reads; responses 0xAAAA then 0x5555 -> s_rsp_valid[0] with rdata 0xAAAA, then s_rsp_valid[1] with 0x5555.
REQ-038 TD=4 with 4 reads outstanding and port 0 requesting a read -> m_req_valid=0 and rd_outstanding=4; a pending write on port 1 is still granted; one response lets the read proceed the next cycle.
REQ-039 Push and pop in the same cycle with rd_outstanding=2 -> stays 2 and routing order is preserved.
REQ-040 m_rsp_valid pulse after reset with nothing outstanding -> no s_rsp_valid; err_orphan_rsp=1 until rst.
